// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default line settings,
// common to the receiver and the transmitter.
package uart_pkg;

  localparam int UART_CLK_HZ = 100_000_000;
  localparam int UART_BAUD   = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // sys_clk cycles per 16x oversample tick
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator: one-cycle tick every DIV clocks, held at
// phase zero while clr_i is high so a frame always starts on a fresh period.
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, 16x oversampled; start and stop
// bits are validated at their midpoints and bytes are held until acknowledged.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = UART_CLK_HZ,
  parameter int BAUD   = UART_BAUD,
  parameter int DIV    = baud_div(CLK_HZ, BAUD)
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_ferr_o,
  output logic       uart_ovr_o,
  output logic       uart_busy_o
);

  logic [1:0]  sync_q;
  logic        rx_s;
  logic        tick;
  logic        tick_clr;
  uart_state_e state_q;
  logic [3:0]  scnt_q;
  logic [2:0]  bcnt_q;
  logic [7:0]  shreg_q;
  logic [7:0]  dat_q;
  logic        valid_q;
  logic        ferr_q;
  logic        ovr_q;
  logic        busy_q;

  assign rx_s     = sync_q[1];
  assign tick_clr = (state_q == ST_IDLE);

  // Flops reset high so a released reset never looks like a start bit.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
    end
  end

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk_i (sys_clk_i),
    .rst_ni(sys_rstn_i),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // Handshake: uart_valid_o is a level that stays high while a byte is held;
  // a cycle with uart_rd_i high pops it and clears both sticky flags on the
  // next edge. A byte delivered in the same cycle as uart_rd_i wins: valid
  // stays high and no overrun is recorded.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q <= ST_IDLE;
      scnt_q  <= 4'd0;
      bcnt_q  <= 3'd0;
      shreg_q <= 8'd0;
      dat_q   <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (uart_rd_i) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (tick && (state_q != ST_IDLE)) begin
        scnt_q <= scnt_q + 4'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            scnt_q  <= 4'd0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick && (scnt_q == 4'd7)) begin
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_DATA;
              scnt_q  <= 4'd0;
              bcnt_q  <= 3'd0;
            end
          end
        end
        ST_DATA: begin
          if (tick && (scnt_q == 4'd15)) begin
            shreg_q[bcnt_q] <= rx_s;
            bcnt_q          <= bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              state_q <= ST_STOP;
              scnt_q  <= 4'd0;
            end
          end
        end
        ST_STOP: begin
          if (tick && (scnt_q == 4'd15)) begin
            if (rx_s) begin
              dat_q   <= shreg_q;
              valid_q <= 1'b1;
              if (valid_q && !uart_rd_i) begin
                ovr_q <= 1'b1;
              end
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // A line held low after a bad stop bit must go high before re-arming.
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_dat_o   = dat_q;
  assign uart_valid_o = valid_q;
  assign uart_ferr_o  = ferr_q;
  assign uart_ovr_o   = ovr_q;
  assign uart_busy_o  = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first, idle-high line; companion to the existing UART transmitter on the same 100 MHz `sys_clk_i` domain. Oversamples the line at 16× baud, validates start and stop bits, and presents each received byte through a level-valid/read-acknowledge handshake. Sticky error flags report framing errors and overruns. Sits between the board RX pin and the core's MMIO/debug console logic.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency
- `BAUD`, 115200, line rate
- `DIV`, `CLK_HZ/(BAUD*16)` (=54), sys_clk cycles per 16× sample tick; minimum 2

- `sys_clk_i` input 1 system clock; the block's only clock
- `sys_rstn_i` input 1 reset: asynchronous, active-low
- `uart_rx_i` input 1 serial line, asynchronous to `sys_clk_i`
- `uart_rd_i` input 1 consumer acknowledge; pops the held byte
- `uart_dat_o` output 8 last received byte
- `uart_valid_o` output 1 byte held and unread
- `uart_ferr_o` output 1 sticky framing error
- `uart_ovr_o` output 1 sticky overrun
- `uart_busy_o` output 1 frame reception in progress (state ≠ IDLE)

## Operation
- Input path: 2-flop synchronizer on `uart_rx_i`; flops reset to 1. All logic uses the synchronized value `rx_s`.
- Tick generator: counter 0..DIV-1. `tick` asserts on the cycle count==DIV-1, then count wraps to 0. Counter forced to 0 whenever state is IDLE.
- Sample counter `scnt`, 4 bits, increments on each tick, wraps 15→0. Bit counter `bcnt`, 3 bits.
- FSM:
  - IDLE: on `rx_s`==0 → START, `scnt`=0.
  - START: on tick with `scnt`==7 (mid start bit): if `rx_s`==1 → IDLE (false start, no flags); else → DATA, `scnt`=0, `bcnt`=0.
  - DATA: on tick with `scnt`==15, shift `rx_s` into bit `bcnt` of the shift register (LSB first). After `bcnt`==7 → STOP, `scnt`=0.
  - STOP: on tick with `scnt`==15 (mid stop bit): if `rx_s`==1 → deliver byte, then IDLE; if 0 → set `uart_ferr_o`, discard byte, then BREAK.
  - BREAK: wait for `rx_s`==1 → IDLE (no spurious start from a held-low line).
- Delivery: `uart_dat_o` ← shift register, `uart_valid_o` ← 1. If `uart_valid_o` was already 1 and no `uart_rd_i` that cycle, set `uart_ovr_o`; the new byte overwrites the old one.
- `uart_rd_i` while `uart_valid_o`==1: next cycle clears `uart_valid_o`, `uart_ferr_o`, `uart_ovr_o`. `uart_rd_i` while `uart_valid_o`==0 clears only the flags. Same-cycle delivery and `uart_rd_i`: the new byte wins; valid stays 1, no overrun.
- Reset (any time, including mid-frame): state IDLE, counters 0, `uart_dat_o`=0, `uart_valid_o`=0, `uart_ferr_o`=0, `uart_ovr_o`=0, `uart_busy_o`=0.

## Timing
- All outputs registered; they change one cycle after the deciding edge.
- Synchronizer latency: 2 cycles from `uart_rx_i` to `rx_s`.
- Start decision at 8·DIV cycles after IDLE→START; data samples at 16·DIV intervals afterward; stop sample at 8·DIV + 9·16·DIV = 8208 cycles (defaults) after the START entry.
- `uart_valid_o` rises 1 cycle after the stop sample, i.e. `uart_rx_i` falling edge + ~8211 cycles.
- `uart_busy_o` is high from the cycle after START entry until the return to IDLE.
- Tolerates ±2% total baud mismatch.

## Structure
- Package `uart_pkg`: FSM state enum (IDLE, START, DATA, STOP, BREAK) and the default `CLK_HZ`/`BAUD` constants, shared with the transmitter.
- One sub-module, `uart_baud_tick`: parameter DIV, inputs clock/reset/sync-clear, output `tick`. It is reusable by a future 16×-oversampled transmitter.

## Test plan
- Send 0x55, then 0xA3, at 115200 with `uart_rd_i` after each → `uart_dat_o`=0x55 then 0xA3, `uart_valid_o` rises 8211±3 cycles after each start edge, no flags.
- 3 µs low glitch on an idle line → no valid, `uart_busy_o` drops within 8·DIV+3 cycles, no flags.
- 0x3C with the stop bit driven low, line held low 2 ms, then released → `uart_ferr_o`=1, valid stays 0, busy stays high until release, and no frame is received on release.
- Two bytes 0x11 and 0x22 with no `uart_rd_i` → `uart_dat_o`=0x22, `uart_ovr_o`=1; `uart_rd_i` clears valid and ovr next cycle.
- Assert `sys_rstn_i` low in the middle of bit 4 of 0xF0, release, then send 0x81 → all outputs 0 during reset, 0x81 received correctly.
- Baud skew: TX at 115200·1.02 and 115200·0.98, 256 random bytes each → all bytes match, zero flags.
